// File: rtl/meta_write_scheduler.sv
// Two-requester metadata write scheduler: a 2-deep FIFO per requester feeding one output register.
// Define META_WRITE_SCHED_AGE_LIMIT_EN to bound port-1 starvation with a 3-bit age counter.
module meta_write_scheduler (
  input  logic        clock,
  input  logic        reset,
  input  logic        io_in_0_valid,
  output logic        io_in_0_ready,
  input  logic [5:0]  io_in_0_bits_idx,
  input  logic [7:0]  io_in_0_bits_way_en,
  input  logic [1:0]  io_in_0_bits_data_coh_state,
  input  logic [20:0] io_in_0_bits_data_tag,
  input  logic        io_in_1_valid,
  output logic        io_in_1_ready,
  input  logic [5:0]  io_in_1_bits_idx,
  input  logic [7:0]  io_in_1_bits_way_en,
  input  logic [1:0]  io_in_1_bits_data_coh_state,
  input  logic [20:0] io_in_1_bits_data_tag,
  input  logic        io_out_ready,
  output logic        io_out_valid,
  output logic [5:0]  io_out_bits_idx,
  output logic [7:0]  io_out_bits_way_en,
  output logic [1:0]  io_out_bits_data_coh_state,
  output logic [20:0] io_out_bits_data_tag,
  output logic        io_out_src,
  output logic        io_busy
);

  localparam int unsigned NPORT = 2;

  typedef struct packed {
    logic [5:0]  idx;
    logic [7:0]  way_en;
    logic [1:0]  coh_state;
    logic [20:0] tag;
  } meta_wr_t;

  meta_wr_t               in_bits [NPORT];
  logic [NPORT-1:0]       in_valid;

  meta_wr_t               mem_q [NPORT][2];
  meta_wr_t               mem_d [NPORT][2];
  logic [NPORT-1:0]       wr_ptr_q, wr_ptr_d;
  logic [NPORT-1:0]       rd_ptr_q, rd_ptr_d;
  logic [NPORT-1:0][1:0]  count_q, count_d;

  logic                   out_valid_q, out_valid_d;
  logic                   out_src_q, out_src_d;
  meta_wr_t               out_bits_q, out_bits_d;

  logic [NPORT-1:0]       ready, head_valid, enq, deq;
  meta_wr_t               head [NPORT];
  logic                   load, sel;

  assign in_valid   = {io_in_1_valid, io_in_0_valid};
  assign in_bits[0] = {io_in_0_bits_idx, io_in_0_bits_way_en,
                       io_in_0_bits_data_coh_state, io_in_0_bits_data_tag};
  assign in_bits[1] = {io_in_1_bits_idx, io_in_1_bits_way_en,
                       io_in_1_bits_data_coh_state, io_in_1_bits_data_tag};

  // Ready is decoded from the occupancy register alone, so io_out_ready never reaches it.
  always_comb begin
    for (int p = 0; p < NPORT; p++) begin
      ready[p]      = (count_q[p] != 2'd2);
      head_valid[p] = (count_q[p] != 2'd0);
      head[p]       = mem_q[p][rd_ptr_q[p]];
      enq[p]        = in_valid[p] & ready[p];
    end
  end

  assign load = (~out_valid_q | io_out_ready) & (|head_valid);

`ifdef META_WRITE_SCHED_AGE_LIMIT_EN
  logic [2:0] age_q, age_d;

  assign sel = head_valid[1] & (~head_valid[0] | (age_q >= 3'd4));

  always_comb begin
    age_d = age_q;
    if (!head_valid[1]) begin
      age_d = 3'd0;
    end else if (load) begin
      age_d = sel ? 3'd0 : age_q + 3'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) age_q <= 3'd0;
    else       age_q <= age_d;
  end
`else
  assign sel = head_valid[1] & ~head_valid[0];
`endif

  assign deq = load ? (sel ? 2'b10 : 2'b01) : 2'b00;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q ^ enq;
    rd_ptr_d = rd_ptr_q ^ deq;
    for (int p = 0; p < NPORT; p++) begin
      count_d[p] = count_q[p] + {1'b0, enq[p]} - {1'b0, deq[p]};
      if (enq[p]) mem_d[p][wr_ptr_q[p]] = in_bits[p];
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_src_d   = out_src_q;
    out_bits_d  = out_bits_q;
    if (load) begin
      out_valid_d = 1'b1;
      out_src_d   = sel;
      out_bits_d  = head[sel];
    end else if (io_out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_src_q   <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_src_q   <= out_src_d;
    end
  end

  // NOTE: payload storage has no reset; validity is carried by the counters and out_valid_q.
  always_ff @(posedge clock) begin
    mem_q      <= mem_d;
    out_bits_q <= out_bits_d;
  end

  assign io_in_0_ready = ready[0];
  assign io_in_1_ready = ready[1];
  assign io_out_valid  = out_valid_q;
  assign io_out_src    = out_src_q;
  assign {io_out_bits_idx, io_out_bits_way_en,
          io_out_bits_data_coh_state, io_out_bits_data_tag} = out_bits_q;
  assign io_busy = (|count_q[0]) | (|count_q[1]) | out_valid_q;

endmodule

// File: tb/tb_meta_write_scheduler.sv
// Scoreboard bench for meta_write_scheduler: a queue-level model predicts each load, a monitor checks handshakes.
module tb_meta_write_scheduler;

  logic        clock = 1'b0;
  logic        reset;
  logic        in0_valid, in1_valid, out_ready;
  logic [5:0]  in0_idx, in1_idx;
  logic [7:0]  in0_way, in1_way;
  logic [1:0]  in0_coh, in1_coh;
  logic [20:0] in0_tag, in1_tag;
  logic        in0_ready, in1_ready, out_valid, out_src, busy;
  logic [5:0]  out_idx;
  logic [7:0]  out_way;
  logic [1:0]  out_coh;
  logic [20:0] out_tag;

  meta_write_scheduler dut (
    .clock                      (clock),
    .reset                      (reset),
    .io_in_0_valid              (in0_valid),
    .io_in_0_ready              (in0_ready),
    .io_in_0_bits_idx           (in0_idx),
    .io_in_0_bits_way_en        (in0_way),
    .io_in_0_bits_data_coh_state(in0_coh),
    .io_in_0_bits_data_tag      (in0_tag),
    .io_in_1_valid              (in1_valid),
    .io_in_1_ready              (in1_ready),
    .io_in_1_bits_idx           (in1_idx),
    .io_in_1_bits_way_en        (in1_way),
    .io_in_1_bits_data_coh_state(in1_coh),
    .io_in_1_bits_data_tag      (in1_tag),
    .io_out_ready               (out_ready),
    .io_out_valid               (out_valid),
    .io_out_bits_idx            (out_idx),
    .io_out_bits_way_en         (out_way),
    .io_out_bits_data_coh_state (out_coh),
    .io_out_bits_data_tag       (out_tag),
    .io_out_src                 (out_src),
    .io_busy                    (busy)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic        src;
    logic [5:0]  idx;
    logic [7:0]  way;
    logic [1:0]  coh;
    logic [20:0] tag;
  } wr_t;

  wr_t q0[$], q1[$], exp_q[$];
  bit  m_ov;
  int  m_streak;
  bit  acc0, acc1;
  int  checks = 0;
  int  failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // One clock edge of the abstract scheduler: output stage first, then enqueues.
  task automatic model_edge();
    bit  r0, r1, h0, h1, load, pick1;
    wr_t item;
    r0 = q0.size() < 2;
    r1 = q1.size() < 2;
    h0 = q0.size() > 0;
    h1 = q1.size() > 0;
    load = (!m_ov || out_ready) && (h0 || h1);
`ifdef META_WRITE_SCHED_AGE_LIMIT_EN
    pick1 = h1 && (!h0 || m_streak >= 4);
`else
    pick1 = h1 && !h0;
`endif
    if (load) begin
      item = pick1 ? q1.pop_front() : q0.pop_front();
      item.src = pick1;
      exp_q.push_back(item);
      m_ov = 1'b1;
    end else if (out_ready) begin
      m_ov = 1'b0;
    end
    if (!h1 || (load && pick1)) m_streak = 0;
    else if (load)              m_streak++;
    acc0 = in0_valid && r0;
    acc1 = in1_valid && r1;
    if (acc0) q0.push_back({1'b0, in0_idx, in0_way, in0_coh, in0_tag});
    if (acc1) q1.push_back({1'b1, in1_idx, in1_way, in1_coh, in1_tag});
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    exp_q.delete();
    m_ov     = 1'b0;
    m_streak = 0;
  endtask

  task automatic status_check();
    check("in_0_ready", in0_ready, q0.size() < 2);
    check("in_1_ready", in1_ready, q1.size() < 2);
    check("out_valid",  out_valid, m_ov);
    check("busy",       busy, (q0.size() > 0) || (q1.size() > 0) || m_ov);
  endtask

  // Inputs are already set; advance one clock and check status at negedge+1.
  task automatic cycle();
    @(posedge clock);
    if (!reset) model_edge();
    @(negedge clock);
    #1;
    status_check();
  endtask

  task automatic rand_payloads();
    in0_idx = 6'($urandom);  in0_way = 8'($urandom);
    in0_coh = 2'($urandom);  in0_tag = 21'($urandom);
    in1_idx = 6'($urandom);  in1_way = 8'($urandom);
    in1_coh = 2'($urandom);  in1_tag = 21'($urandom);
  endtask

  // Monitor: every output handshake must match the oldest predicted load.
  initial begin
    wr_t req;
    forever begin
      @(negedge clock);
      #2;
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL out_unexpected actual src=%0d idx=%0d tag=0x%0h required=no write",
                   out_src, out_idx, out_tag);
        end else begin
          req = exp_q.pop_front();
          check("out_payload", {out_src, out_idx, out_way, out_coh, out_tag}, req);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=still running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    wr_t items [4];
    int  k;
    reset = 1'b1;
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b0;
    rand_payloads();
    model_clear();
    @(negedge clock); @(negedge clock); #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy",      busy, 0);
    check("rst_src",       out_src, 0);
    check("rst_in_0_ready", in0_ready, 1);
    check("rst_in_1_ready", in1_ready, 1);
    reset = 1'b0;

    // Single write latency: handshake edge, load edge, then idle.
    in0_valid = 1'b1; in0_idx = 6'd5; in0_tag = 21'h1ABCD; in0_way = 8'h04; in0_coh = 2'd2;
    out_ready = 1'b1;
    cycle();
    in0_valid = 1'b0;
    check("no_fall_through", out_valid, 0);
    cycle();
    check("lat_out_valid", out_valid, 1);
    check("lat_idx", out_idx, 6'd5);
    check("lat_tag", out_tag, 21'h1ABCD);
    check("lat_src", out_src, 0);
    cycle();
    check("lat_busy_fall", busy, 0);

    // Stalled output: A,B,C,D offered back-to-back on port 0, each held until accepted.
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      items[i] = {1'b0, 6'(10 + i), 8'(1 << i), 2'(i), 21'(21'h0A000 + i)};
    end
    k = 0;
    for (int c = 0; c < 6; c++) begin
      in0_valid = (k < 4);
      {in0_idx, in0_way, in0_coh, in0_tag} = items[k % 4][36:0];
      cycle();
      if (acc0) k++;
    end
    check("stall_in_0_ready", in0_ready, 0);
    check("stall_accepted", k, 3);
    out_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      in0_valid = (k < 4);
      {in0_idx, in0_way, in0_coh, in0_tag} = items[k % 4][36:0];
      cycle();
      if (acc0) k++;
    end
    check("stall_all_accepted", k, 4);

    // Random traffic with random backpressure.
    for (int c = 0; c < 300; c++) begin
      in0_valid = 1'($urandom_range(0, 1));
      in1_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 9) < 7);
      rand_payloads();
      cycle();
    end
    in0_valid = 1'b0; in1_valid = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 8; c++) cycle();

    // Both ports saturated with out_ready high.
    for (int c = 0; c < 40; c++) begin
      in0_valid = 1'b1; in1_valid = 1'b1; out_ready = 1'b1;
      rand_payloads();
      cycle();
    end
`ifndef META_WRITE_SCHED_AGE_LIMIT_EN
    check("starved_in_1_ready", in1_ready, 0);
`endif
    in0_valid = 1'b0; in1_valid = 1'b0;
    for (int c = 0; c < 10; c++) cycle();

    // Fill everything, then assert reset between edges.
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in0_valid = 1'b1; in1_valid = 1'b1;
      rand_payloads();
      cycle();
    end
    check("fill_q0", q0.size(), 2);
    check("fill_q1", q1.size(), 2);
    #2;
    reset = 1'b1;
    #1;
    check("async_out_valid", out_valid, 0);
    check("async_busy", busy, 0);
    model_clear();
    in0_valid = 1'b0; in1_valid = 1'b0;
    @(negedge clock); #1;
    reset = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 6; c++) cycle();

    // Final drain.
    for (int c = 0; c < 10 && exp_q.size() > 0; c++) cycle();
    check("drain_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
